// File: rtl/stream_mux_pkg.sv
// Shared constants for the 2-to-1 stream multiplexer: source tags and the
// arbiter's reset value.
package stream_mux_pkg;

    localparam logic SEL_I0         = 1'b0;
    localparam logic SEL_I1         = 1'b1;
    // Starting with source 1 as "last served" lets source 0 win the first contention.
    localparam logic RST_LAST_GRANT = 1'b1;

endpackage

// File: rtl/stream_mux_2to1_arbiter.sv
// Two-requester arbiter for stream_mux_2to1: round-robin by default,
// fixed priority to requester 0 when STREAM_MUX_FIXED_PRIO_EN is defined.
module rr_arbiter_2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       grant_valid
);

`ifdef STREAM_MUX_FIXED_PRIO_EN

    always_comb begin
        grant_valid = |req;
        grant       = req[0] ? SEL_I0 : SEL_I1;
    end

`else

    logic last_grant;

    // Remember who was served only when a transfer actually happened,
    // so a stalled output does not rotate the priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= RST_LAST_GRANT;
        end else if (advance) begin
            last_grant <= grant;
        end
    end

    always_comb begin
        grant_valid = |req;
        grant       = SEL_I0;
        case (req)
            2'b01:   grant = SEL_I0;
            2'b10:   grant = SEL_I1;
            2'b11:   grant = ~last_grant;
            default: grant = SEL_I0;
        endcase
    end

`endif

endmodule

// File: rtl/stream_mux_2to1.sv
// Merges two valid/ready streams into one registered output stage tagged with
// its source. STREAM_MUX_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module stream_mux_2to1
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i0_data,
    input  logic              i0_valid,
    output logic              i0_ready,
    input  logic [DATA_W-1:0] i1_data,
    input  logic              i1_valid,
    output logic              i1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sel
);

    logic load_en;
    logic grant;
    logic grant_valid;
    logic accept;

    rr_arbiter_2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         ({i1_valid, i0_valid}),
        .advance     (accept),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        load_en  = ~out_valid | out_ready;
        i0_ready = rst_n & load_en & grant_valid & (grant == SEL_I0) & i0_valid;
        i1_ready = rst_n & load_en & grant_valid & (grant == SEL_I1) & i1_valid;
        accept   = i0_ready | i1_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sel   <= SEL_I0;
            out_valid <= 1'b0;
        end else if (load_en) begin
            if (accept) begin
                out_data  <= (grant == SEL_I1) ? i1_data : i0_data;
                out_sel   <= grant;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
